// File: rtl/rst_seq_multi_pkg.sv
// Shared types and constants for the multi-domain reset sequencer.
package rst_seq_multi_pkg;

  typedef enum logic [1:0] {
    WaitLock = 2'd0,
    PorHold  = 2'd1,
    Release  = 2'd2,
    Run      = 2'd3
  } state_e;

  localparam int CauseWidth = 4;
  localparam int CausePor   = 0;
  localparam int CauseBtn   = 1;
  localparam int CauseSw    = 2;
  localparam int CauseWdog  = 3;

  // After reset the only known cause is power-on.
  localparam logic [CauseWidth-1:0] CauseResetVal = 4'b0001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_multi_debounce.sv
// Button debouncer: the debounced level follows the raw input only after
// DebounceCycles consecutive cycles of disagreement. The rise pulse is
// asserted in the cycle whose clock edge sets the level high.
module rst_seq_debounce
  import rst_seq_multi_pkg::*;
#(
  parameter int DebounceCycles = 65536
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DebounceCycles);

  logic [CntW-1:0] cnt_reg;
  logic            level_reg;
  logic            differ;
  logic            expire;

  assign differ = (raw != level_reg);
  assign expire = differ && (cnt_reg == CntLast);

  // Count consecutive disagreement cycles; flip the level once they reach the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (!differ) begin
      cnt_reg <= '0;
    end else if (expire) begin
      cnt_reg   <= '0;
      level_reg <= raw;
    end else if (cnt_reg != CntMax) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign level = level_reg;
  assign rise  = expire && raw;

endmodule

// File: rtl/rst_seq_multi.sv
// Multi-domain reset sequencer: holds all domain resets until PLL lock plus
// a power-on delay, then releases domains in index order with a fixed
// stagger. Button, software and (optionally) watchdog requests restart the
// hold; cause bits are sticky until cleared.
// Optional watchdog: define RST_SEQ_MULTI_WDOG_EN.
module rst_seq_multi
  import rst_seq_multi_pkg::*;
#(
  parameter int NumDomains     = 4,
  parameter int PorCycles      = 1024,
  parameter int StaggerCycles  = 16,
  parameter int DebounceCycles = 65536
`ifdef RST_SEQ_MULTI_WDOG_EN
  ,
  parameter int WdogCycles     = 2**20
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  input  logic                  rst_btn_i,
  input  logic                  sw_rst_req_i,
  input  logic                  cause_clr_i,
`ifdef RST_SEQ_MULTI_WDOG_EN
  input  logic                  wdog_kick_i,
`endif
  output logic [NumDomains-1:0] rst_no,
  output logic                  run_o,
  output logic [CauseWidth-1:0] rst_cause_o
);

  localparam int HoldW = $clog2(max_int(PorCycles, StaggerCycles) + 1);
  localparam int IdxW  = (NumDomains > 1) ? $clog2(NumDomains) : 1;
  // PorHold spans PorCycles+1 cycles from lock so rst_no[0] lands one cycle later.
  localparam logic [HoldW-1:0] HoldPorLast = HoldW'(PorCycles);
  localparam logic [HoldW-1:0] HoldStgLast = HoldW'(StaggerCycles - 1);
  localparam logic [IdxW-1:0]  IdxPenult   = IdxW'(NumDomains - 2);

  state_e                  state_reg, state_next;
  logic [HoldW-1:0]        hold_cnt_reg, hold_cnt_next;
  logic [IdxW-1:0]         idx_reg, idx_next;
  logic [NumDomains-1:0]   rst_no_reg, rst_no_next;
  logic                    run_reg, run_next;
  logic [CauseWidth-1:0]   cause_reg, cause_next;
  logic                    btn_level, btn_rise, btn_event;
  logic                    wdog_expire;
  logic                    req;

  rst_seq_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_debounce (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw   (rst_btn_i),
    .level (btn_level),
    .rise  (btn_rise)
  );

  // The rise pulse only counts while the registered level is still low.
  assign btn_event = btn_rise && !btn_level;

`ifdef RST_SEQ_MULTI_WDOG_EN
  localparam int WdogW = $clog2(WdogCycles + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WdogCycles - 1);
  localparam logic [WdogW-1:0] WdogMax  = WdogW'(WdogCycles);

  logic [WdogW-1:0] wdog_cnt_reg;

  assign wdog_expire = (state_reg == Run) && !wdog_kick_i && (wdog_cnt_reg == WdogLast);

  // Watchdog runs only in Run; a kick or an expiry starts it over.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_reg != Run) || wdog_kick_i || wdog_expire) begin
      wdog_cnt_reg <= '0;
    end else if (wdog_cnt_reg != WdogMax) begin
      wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  assign req = btn_event || sw_rst_req_i || wdog_expire;

  // State register with hold counter and release index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= WaitLock;
      hold_cnt_reg <= '0;
      idx_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      idx_reg      <= idx_next;
    end
  end

  // Next-state logic: lock loss beats requests, requests beat sequencing.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    idx_next      = idx_reg;
    if (!pll_locked_i) begin
      state_next    = WaitLock;
      hold_cnt_next = '0;
      idx_next      = '0;
    end else if (state_reg == WaitLock) begin
      state_next    = PorHold;
      hold_cnt_next = '0;
      idx_next      = '0;
    end else if (req) begin
      state_next    = PorHold;
      hold_cnt_next = '0;
      idx_next      = '0;
    end else begin
      case (state_reg)
        PorHold: begin
          if (hold_cnt_reg == HoldPorLast) begin
            hold_cnt_next = '0;
            idx_next      = '0;
            state_next    = (NumDomains == 1) ? Run : Release;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        Release: begin
          if (hold_cnt_reg == HoldStgLast) begin
            hold_cnt_next = '0;
            idx_next      = idx_reg + 1'b1;
            if (idx_reg == IdxPenult) begin
              state_next = Run;
            end
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from the next state so outputs register alongside the state.
  always_comb begin
    rst_no_next = '0;
    for (int k = 0; k < NumDomains; k++) begin
      rst_no_next[k] = (state_next == Run) ||
                       ((state_next == Release) && (int'(idx_next) >= k));
    end
    run_next = (state_next == Run);
  end

  // Sticky cause bits: a new event in the same cycle outranks the clear.
  always_comb begin
    cause_next = cause_clr_i ? '0 : cause_reg;
    cause_next[CausePor]  = cause_next[CausePor]  | !pll_locked_i;
    cause_next[CauseBtn]  = cause_next[CauseBtn]  | btn_event;
    cause_next[CauseSw]   = cause_next[CauseSw]   | sw_rst_req_i;
    cause_next[CauseWdog] = cause_next[CauseWdog] | wdog_expire;
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_no_reg <= '0;
      run_reg    <= 1'b0;
      cause_reg  <= CauseResetVal;
    end else begin
      rst_no_reg <= rst_no_next;
      run_reg    <= run_next;
      cause_reg  <= cause_next;
    end
  end

  assign rst_no      = rst_no_reg;
  assign run_o       = run_reg;
  assign rst_cause_o = cause_reg;

endmodule

// File: doc/rst_seq_multi.md
Name: rst_seq_multi

Overview:
- Parametrised multi-domain reset sequencer in the board clock domain, sitting between PLL/button inputs and the per-domain reset synchronisers.
- Generalises the single board-reset scheme to NumDomains reset outputs.
- Adds:
  - staggered, ordered release
  - power-on hold after PLL lock
  - debounced button
  - software reset request
  - sticky reset-cause reporting
- Each rst_no bit feeds a 2-flop synchroniser in its target domain; those synchronisers are outside this block.

Parameters:
- NumDomains, 4: number of reset outputs; released in index order 0..NumDomains-1; range 1..16.
- PorCycles, 1024: clk_i cycles to hold all resets after PLL lock or after any reset request ends; must be >=1.
- StaggerCycles, 16: clk_i cycles between consecutive domain releases; must be >=1.
- DebounceCycles, 65536: consecutive stable cycles required before the debounced button changes; must be >=1.

Ports:
- clk_i  in  1  board clock
- rst_i  in  1  synchronous active-high reset
- pll_locked_i  in  1  PLL lock indication, already synchronised to clk_i
- rst_btn_i  in  1  reset button, active-high, already synchronised to clk_i
- sw_rst_req_i  in  1  software reset request, single-cycle pulse
- cause_clr_i  in  1  clears rst_cause_o
- rst_no  out  NumDomains  per-domain reset, active-low
- run_o  out  1  high once all domains are released
- rst_cause_o  out  4  sticky cause bits: [0] POR/lock-loss, [1] button, [2] software, [3] watchdog

Behaviour:
- Reset (rst_i=1):
  - state=WaitLock, rst_no=0, run_o=0, rst_cause_o=4'b0001
  - debounced button=0, counters=0
- Hold-counter width: $clog2(max(PorCycles,StaggerCycles)+1). Debounce counter width: $clog2(DebounceCycles+1). Counters saturate and never wrap.
- Debounce: if raw differs from debounced for DebounceCycles consecutive cycles, debounced takes the raw value. Any cycle of agreement zeroes the counter. A button event is a 0->1 edge of the debounced value.
- FSM states:
  - WaitLock: all rst_no=0. Leave to PorHold in the cycle after pll_locked_i is sampled high.
  - PorHold: all rst_no=0; counts PorCycles. In the final count cycle go to Release with idx=0. rst_no[0] rises exactly PorCycles+1 cycles after pll_locked_i is first sampled high.
  - Release: on entry set rst_no[idx]=1. Wait StaggerCycles, then idx++. rst_no[k] rises StaggerCycles*k cycles after rst_no[0]. When the last domain is released, go to Run; run_o rises in the same cycle as rst_no[NumDomains-1].
  - Run: hold all rst_no=1, run_o=1.
- Reset requests (button event or sw_rst_req_i) in PorHold, Release or Run:
  - next cycle: all rst_no=0, run_o=0, state=PorHold, counter restarts
  - requests during PorHold restart the hold count
- pll_locked_i low in any state has highest priority: next cycle go to WaitLock with all outputs asserted, and set cause[0].
- Cause bits:
  - set in the same cycle the triggering event is sampled
  - simultaneous events set multiple bits
  - cause_clr_i clears all bits; a set in the same cycle wins over the clear
- No output changes combinationally from inputs; all outputs are registered.

Optional Feature:
- Macro: RST_SEQ_MULTI_WDOG_EN.
- When defined:
  - adds parameter WdogCycles (default 2**20) and input wdog_kick_i (1 bit)
  - in Run, a counter increments each cycle and is zeroed by wdog_kick_i
  - reaching WdogCycles acts as a reset request and sets cause[3]
  - the counter is held at 0 outside Run
- When undefined: no port, no counter, cause[3] is tied to 0.

Decomposition:
- Package rst_seq_multi_pkg:
  - state enum (WaitLock, PorHold, Release, Run)
  - cause bit index constants (CausePor=0, CauseBtn=1, CauseSw=2, CauseWdog=3)
  - CauseWidth=4
- Sub-module rst_seq_debounce, parametrised by DebounceCycles: outputs the debounced level and a rise pulse.

Test Plan (NumDomains=3, PorCycles=8, StaggerCycles=4, DebounceCycles=4):
- rst_i released, pll_locked_i rises at cycle 10 -> rst_no[0]=1 at cycle 19, rst_no[1]=1 at 23, rst_no[2]=1 and run_o=1 at 27; rst_cause_o=4'b0001.
- In Run, rst_btn_i high for 3 cycles then low -> no reset. rst_btn_i high for 4 cycles -> all rst_no=0 in the following cycle; cause[1] set; full release sequence repeats.
- In Run, sw_rst_req_i pulse in the same cycle as a debounced button edge -> single reset sequence; rst_cause_o=4'b0111 if not cleared beforehand.
- pll_locked_i drops while idx=1 in Release -> next cycle all rst_no=0 in WaitLock. On relock the sequence restarts from domain 0.
- cause_clr_i asserted in the same cycle as sw_rst_req_i -> rst_cause_o=4'b0100.
- With RST_SEQ_MULTI_WDOG_EN and WdogCycles=16: no kick for 16 cycles in Run -> reset sequence, cause[3]=1. Kicking every 10 cycles -> no reset.
